bus_mux: RTL and testbench

BUS_MUX -- requirements
Module: bus_mux

---
 rtl/bus_mux.sv | 117 +++++++++++
 tb/tb_bus_mux.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bus_mux.sv
// Purpose: registered 24-source bus multiplexer driven by a one-hot select,
//          where the lowest set select bit wins.
// Latency: one cycle from EncIn/sources to busOut/sel_code/sel_err.
// Backpressure: none. The output register is loaded on every clock edge.
//
// Ports:
//   clk, clr            clock and synchronous active-high clear
//   EncIn[23:0]         one-hot source select; index to source mapping:
//                       0..15 busin0..busin15, 16 hi, 17 lo, 18 Zhi, 19 Zlo,
//                       20 PC, 21 MDR, 22 Inport, 23 csignextended
//   busOut              registered value of the selected source
//   sel_code[4:0]       registered index of the selected source, 31 if none
//   sel_err             registered flag, set when EncIn had more than one bit set
module bus_mux #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [23:0]       EncIn,
  input  logic [DATA_W-1:0] busin0,
  input  logic [DATA_W-1:0] busin1,
  input  logic [DATA_W-1:0] busin2,
  input  logic [DATA_W-1:0] busin3,
  input  logic [DATA_W-1:0] busin4,
  input  logic [DATA_W-1:0] busin5,
  input  logic [DATA_W-1:0] busin6,
  input  logic [DATA_W-1:0] busin7,
  input  logic [DATA_W-1:0] busin8,
  input  logic [DATA_W-1:0] busin9,
  input  logic [DATA_W-1:0] busin10,
  input  logic [DATA_W-1:0] busin11,
  input  logic [DATA_W-1:0] busin12,
  input  logic [DATA_W-1:0] busin13,
  input  logic [DATA_W-1:0] busin14,
  input  logic [DATA_W-1:0] busin15,
  input  logic [DATA_W-1:0] businhi,
  input  logic [DATA_W-1:0] businlo,
  input  logic [DATA_W-1:0] businZhi,
  input  logic [DATA_W-1:0] businZlo,
  input  logic [DATA_W-1:0] businPC,
  input  logic [DATA_W-1:0] businMDR,
  input  logic [DATA_W-1:0] businInport,
  input  logic [DATA_W-1:0] csignextended,
  output logic [DATA_W-1:0] busOut,
  output logic [4:0]        sel_code,
  output logic              sel_err
);

  localparam logic [4:0] NO_SEL = 5'd31;

  logic [DATA_W-1:0] bus_d,  bus_q;
  logic [4:0]        code_d, code_q;
  logic              err_d,  err_q;

  // Priority encoder: the scan runs from the top index down, so the last
  // (lowest) set bit overwrites and wins.
  always_comb begin
    code_d = NO_SEL;
    for (int i = 23; i >= 0; i--) begin
      if (EncIn[i]) code_d = 5'(i);
    end
  end

  // Clearing the lowest set bit leaves something behind only if more than
  // one bit was set.
  assign err_d = |(EncIn & (EncIn - 24'd1));

  // Selecting by encoded index keeps unselected sources (even unknown ones)
  // out of the result entirely.
  always_comb begin
    bus_d = '0;
    case (code_d)
      5'd0:  bus_d = busin0;
      5'd1:  bus_d = busin1;
      5'd2:  bus_d = busin2;
      5'd3:  bus_d = busin3;
      5'd4:  bus_d = busin4;
      5'd5:  bus_d = busin5;
      5'd6:  bus_d = busin6;
      5'd7:  bus_d = busin7;
      5'd8:  bus_d = busin8;
      5'd9:  bus_d = busin9;
      5'd10: bus_d = busin10;
      5'd11: bus_d = busin11;
      5'd12: bus_d = busin12;
      5'd13: bus_d = busin13;
      5'd14: bus_d = busin14;
      5'd15: bus_d = busin15;
      5'd16: bus_d = businhi;
      5'd17: bus_d = businlo;
      5'd18: bus_d = businZhi;
      5'd19: bus_d = businZlo;
      5'd20: bus_d = businPC;
      5'd21: bus_d = businMDR;
      5'd22: bus_d = businInport;
      5'd23: bus_d = csignextended;
      default: bus_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      bus_q  <= '0;
      code_q <= NO_SEL;
      err_q  <= 1'b0;
    end else begin
      bus_q  <= bus_d;
      code_q <= code_d;
      err_q  <= err_d;
    end
  end

  assign busOut   = bus_q;
  assign sel_code = code_q;
  assign sel_err  = err_q;

endmodule

// File: tb/tb_bus_mux.sv
module tb_bus_mux;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          clr;
  logic [23:0]   enc;
  logic [W-1:0]  src [24];
  logic [W-1:0]  busOut;
  logic [4:0]    sel_code;
  logic          sel_err;

  always #5 clk = ~clk;

  bus_mux #(.DATA_W(W)) dut (
    .clk(clk), .clr(clr), .EncIn(enc),
    .busin0(src[0]),   .busin1(src[1]),   .busin2(src[2]),   .busin3(src[3]),
    .busin4(src[4]),   .busin5(src[5]),   .busin6(src[6]),   .busin7(src[7]),
    .busin8(src[8]),   .busin9(src[9]),   .busin10(src[10]), .busin11(src[11]),
    .busin12(src[12]), .busin13(src[13]), .busin14(src[14]), .busin15(src[15]),
    .businhi(src[16]), .businlo(src[17]), .businZhi(src[18]), .businZlo(src[19]),
    .businPC(src[20]), .businMDR(src[21]), .businInport(src[22]),
    .csignextended(src[23]),
    .busOut(busOut), .sel_code(sel_code), .sel_err(sel_err)
  );

  typedef struct packed {
    logic [W-1:0] dat;
    logic [4:0]   code;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: lowest set bit wins, multi-hot flagged.
  function automatic exp_t model(input logic r, input logic [23:0] e);
    exp_t x;
    x.dat  = '0;
    x.code = 5'd31;
    x.err  = 1'b0;
    if (!r) begin
      for (int i = 0; i < 24; i++) begin
        if (e[i]) begin
          x.code = 5'(i);
          x.dat  = src[i];
          break;
        end
      end
      x.err = ($countones(e) > 1);
    end
    return x;
  endfunction

  // Apply inputs, clock once, then compare the DUT output against the
  // oldest queued expectation.
  task automatic edge_and_compare(input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      check({tag, "_bus"},  busOut,          x.dat);
      check({tag, "_code"}, {27'd0, sel_code}, {27'd0, x.code});
      check({tag, "_err"},  {31'd0, sel_err},  {31'd0, x.err});
    end
  endtask

  task automatic cycle_exp(input logic r, input logic [23:0] e,
                           input logic [W-1:0] d, input logic [4:0] c,
                           input logic er, input string tag);
    exp_t x;
    clr = r;
    enc = e;
    x.dat = d; x.code = c; x.err = er;
    exp_q.push_back(x);
    edge_and_compare(tag);
  endtask

  task automatic cycle_model(input logic r, input logic [23:0] e, input string tag);
    clr = r;
    enc = e;
    exp_q.push_back(model(r, e));
    edge_and_compare(tag);
  endtask

  initial begin
    logic [23:0] e;
    clr = 1'b1;
    enc = '0;
    for (int i = 0; i < 24; i++) src[i] = 32'h1000_0000 + 32'(i);
    src[0] = 32'd23;

    // Reset wins over a valid selection.
    cycle_exp(1'b1, 24'h000001, 32'd0, 5'd31, 1'b0, "reset");
    cycle_exp(1'b0, 24'h000001, 32'd23, 5'd0, 1'b0, "sel0");

    src[12] = 32'd1; src[0] = 32'd0;
    cycle_exp(1'b0, 24'h001000, 32'd1, 5'd12, 1'b0, "sel12");
    src[3] = 32'hDEADBEEF;
    src[5] = 'x;
    cycle_exp(1'b0, 24'h000008, 32'hDEADBEEF, 5'd3, 1'b0, "sel3");
    src[5] = 32'h1000_0005;

    src[20] = 32'd1;
    cycle_exp(1'b0, 24'h100000, 32'd1, 5'd20, 1'b0, "selPC");
    src[23] = 32'hFFFF_FFFC;
    cycle_exp(1'b0, 24'h800000, 32'hFFFF_FFFC, 5'd23, 1'b0, "selCSX");

    cycle_exp(1'b0, 24'h000000, 32'd0, 5'd31, 1'b0, "none");
    src[2] = 32'd5; src[16] = 32'd9;
    cycle_exp(1'b0, 24'h010004, 32'd5, 5'd2, 1'b1, "multi");

    // Mid-stream clear, then recovery on the next edge.
    src[21] = 32'd7;
    cycle_exp(1'b1, 24'h200000, 32'd0, 5'd31, 1'b0, "midclr");
    cycle_exp(1'b0, 24'h200000, 32'd7, 5'd21, 1'b0, "postclr");

    // Output must hold while the selected source changes between edges.
    src[4] = 32'h0000_00AA;
    cycle_exp(1'b0, 24'h000010, 32'h0000_00AA, 5'd4, 1'b0, "sel4");
    src[4] = 32'h0000_0055;
    enc = 24'h000020;
    #3;
    check("hold_bus", busOut, 32'h0000_00AA);
    check("hold_code", {27'd0, sel_code}, 32'd4);

    // Randomised patterns: zero, one-hot and multi-hot selects.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 24; i++) src[i] = $urandom;
      case ($urandom_range(0, 3))
        0:       e = 24'd0;
        1, 2:    e = 24'd1 << $urandom_range(0, 23);
        default: e = 24'($urandom) | (24'd1 << $urandom_range(0, 23));
      endcase
      cycle_model(($urandom_range(0, 9) == 0), e, "rand");
    end

    if (exp_q.size() != 0) check("queue_drain", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
